// File: rtl/branch_history_predictor.sv
// rtl/branch_history_predictor.sv - 2-bit saturating counter branch direction predictor (bimodal or gshare)
//
// Purpose: table of 2**IDX_W two-bit counters indexed by fetch PC bits, optionally
// XORed with a global history register. Fetch gets a registered prediction one cycle
// after a lookup. The execute stage trains the counters through the resolve port.
//
// Optional feature macro: GSHARE_EN
//   defined   : index = FetchPC_i[IDX_W+1:2] ^ GHR, GHR shifts in each resolved outcome
//   undefined : bimodal, index = FetchPC_i[IDX_W+1:2], no history register
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   FetchValid_i          lookup request this cycle
//   FetchPC_i             PC of the fetched instruction
//   PredValid_o           prediction valid (one cycle after the request)
//   PredTaken_o           predicted direction, 1 = taken
//   PredIdx_o             table index used, returned later as ResIdx_i
//   ResValid_i            a conditional branch resolved this cycle
//   ResTaken_i            actual outcome
//   ResPredTaken_i        prediction originally given to the branch
//   ResIdx_i              index originally returned in PredIdx_o
//   Mispredict_o          combinational misprediction flag
module branch_history_predictor #(
    parameter int IDX_W = 6,
    parameter int GHR_W = IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             FetchValid_i,
    input  logic [31:0]      FetchPC_i,
    output logic             PredValid_o,
    output logic             PredTaken_o,
    output logic [IDX_W-1:0] PredIdx_o,
    input  logic             ResValid_i,
    input  logic             ResTaken_i,
    input  logic             ResPredTaken_i,
    input  logic [IDX_W-1:0] ResIdx_i,
    output logic             Mispredict_o
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       cnt_q [DEPTH];
    logic [IDX_W-1:0] lookup_idx;
    logic [1:0]       res_cnt;
    logic [1:0]       res_cnt_next;
    logic [1:0]       pred_cnt;

    // Only the word-aligned index bits of the PC select a counter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{FetchPC_i[31:IDX_W+2], FetchPC_i[1:0]};

`ifdef GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    // History is non-speculative: it only advances when a branch resolves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else if (ResValid_i) begin
            ghr_q <= {ghr_q[GHR_W-2:0], ResTaken_i};
        end
    end

    assign lookup_idx = FetchPC_i[IDX_W+1:2] ^ ghr_q;
`else
    logic [GHR_W-1:0] unused_ghr_w;
    assign unused_ghr_w = '0;

    assign lookup_idx = FetchPC_i[IDX_W+1:2];
`endif

    // Saturating next value of the counter being trained.
    always_comb begin
        res_cnt      = cnt_q[ResIdx_i];
        res_cnt_next = res_cnt;
        if (ResTaken_i) begin
            if (res_cnt != 2'b11) begin
                res_cnt_next = res_cnt + 2'd1;
            end
        end else begin
            if (res_cnt != 2'b00) begin
                res_cnt_next = res_cnt - 2'd1;
            end
        end
    end

    // Write-first bypass: a lookup colliding with this cycle's update sees the trained value.
    always_comb begin
        pred_cnt = cnt_q[lookup_idx];
        if (ResValid_i && (ResIdx_i == lookup_idx)) begin
            pred_cnt = res_cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (ResValid_i) begin
            cnt_q[ResIdx_i] <= res_cnt_next;
        end
    end

    // PredIdx_o deliberately holds on idle cycles; valid and taken drop to 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            PredValid_o <= 1'b0;
            PredTaken_o <= 1'b0;
            PredIdx_o   <= '0;
        end else if (FetchValid_i) begin
            PredValid_o <= 1'b1;
            PredTaken_o <= pred_cnt[1];
            PredIdx_o   <= lookup_idx;
        end else begin
            PredValid_o <= 1'b0;
            PredTaken_o <= 1'b0;
        end
    end

    assign Mispredict_o = ResValid_i & (ResTaken_i != ResPredTaken_i);

endmodule

// File: doc/branch_history_predictor.md
# branch_history_predictor

Dynamic conditional-branch direction predictor for the RV32I pipeline: a table of 2-bit saturating counters indexed by the fetch PC, optionally hashed with a global history register (gshare). Fetch looks up a prediction. The execute stage later retires the actual outcome through the update port. This is the branch comparator's taken flag, carried back as `ResTaken_i`. The block trains the counters and flags mispredictions, closing the loop between comparator and fetch.

## Interface
Parameters:
- `IDX_W`, 6: table index width; table depth = 2**IDX_W counters.
- `GHR_W`, IDX_W: global history length; must equal IDX_W.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `FetchValid_i`  in  1  lookup request this cycle.
- `FetchPC_i`  in  32  PC of the fetched instruction.
- `PredValid_o`  out  1  prediction valid (one cycle after the request).
- `PredTaken_o`  out  1  predicted direction; 1 = taken.
- `PredIdx_o`  out  IDX_W  table index used; pipelined with the instruction, returned as `ResIdx_i`.
- `ResValid_i`  in  1  a conditional branch resolved this cycle.
- `ResTaken_i`  in  1  actual outcome from the branch comparator.
- `ResPredTaken_i`  in  1  prediction originally given to this branch.
- `ResIdx_i`  in  IDX_W  index originally returned in `PredIdx_o`.
- `Mispredict_o`  out  1  combinational: `ResValid_i & (ResTaken_i != ResPredTaken_i)`.

## Operation
- State consists of:
  - 2**IDX_W counters, 2 bits each: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - GHR of GHR_W bits.
- Reset:
  - All counters are set to 01.
  - GHR is set to 0.
  - `PredValid_o`, `PredTaken_o` and `PredIdx_o` are 0.
- Lookup index: `FetchPC_i[IDX_W+1:2] ^ GHR`. The GHR value used is the one at the start of the cycle.
- Prediction: MSB of the selected counter.
- Update when `ResValid_i` is high:
  - `counter[ResIdx_i]` saturating-increments if `ResTaken_i` is 1.
  - Otherwise it saturating-decrements.
  - It never wraps: 11 stays 11 when taken, 00 stays 00 when not taken.
- GHR update when `ResValid_i` is high: `GHR <= {GHR[GHR_W-2:0], ResTaken_i}`. GHR advances only on resolve (non-speculative). There is no recovery path.
- Same cycle, same index: when a lookup and an update hit the same index, the prediction uses the post-update counter value (write-first bypass).
- Same cycle, different indices: a lookup and an update to different indices proceed independently.
- `ResIdx_i` is trusted. Out-of-range indices cannot occur because the width is exact.
- Asserting `rst_ni` mid-operation immediately clears all state and outputs. The first lookup after release sees weak-NT everywhere.

## Timing
- Lookup latency is 1 cycle. A request in cycle N yields `PredValid_o`, `PredTaken_o` and `PredIdx_o` registered at the edge ending cycle N, valid in cycle N+1.
- If `FetchValid_i` is low in cycle N:
  - `PredValid_o` and `PredTaken_o` are 0 in N+1.
  - `PredIdx_o` holds its previous value.
- Back-to-back lookups are accepted every cycle. No stall or backpressure.
- Updates take effect at the edge ending the resolve cycle. The only exception is same-cycle lookup visibility through the bypass.
- `Mispredict_o` has zero latency. It is purely combinational from the resolve inputs.

## Configuration
- `GSHARE_EN` defined:
  - Lookup index is the PC bits XOR GHR, as above.
  - The GHR register is present.
- `GSHARE_EN` undefined:
  - Bimodal predictor; lookup index = `FetchPC_i[IDX_W+1:2]`.
  - GHR is not instantiated, so resolve does not shift any history.
  - All other behaviour is identical.

## Test plan
- Reset then lookup:
  - Stimulus: reset, release, lookup at PC 0x0000_0040.
  - Required: next cycle `PredValid_o`=1, `PredTaken_o`=0, `PredIdx_o`=0x10.
- Saturation:
  - Stimulus: 4 resolves taken at idx 0x10.
  - Required: counter reaches 11 and stays there.
  - Follow-up: 1 not-taken resolve gives 10, and a lookup still predicts taken.
- Mispredict:
  - `ResValid_i`=1, `ResTaken_i`=1, `ResPredTaken_i`=0 gives `Mispredict_o`=1 in the same cycle.
  - `ResValid_i`=0 with the same values gives 0.
- Bypass:
  - Stimulus: counter[5]=01; in one cycle, resolve taken at idx 5 and look up a PC mapping to idx 5.
  - Required: `PredTaken_o`=1 next cycle.
- Gshare (`GSHARE_EN`):
  - Stimulus: resolve outcomes 1,0,1 (GHR=0b000101), then look up PC 0x0000_0040.
  - Required: `PredIdx_o`=0x15.
  - Without `GSHARE_EN` the same stimulus gives 0x10.
- Async reset:
  - Stimulus: drop `rst_ni` mid-stream between clock edges.
  - Required: outputs go to 0 immediately, and all counters read back 01.
